mac_tx_sched: RTL and testbench
===============================

Name: mac_tx_sched

Overview:
Round-robin scheduler that shares the single UDP/MAC transmitter (mac, RMII, 50 MHz) between N frame sources (e.g. camera payload, status/heartbeat). It arbitrates requests, starts one frame at a time, drives the per-frame length and IPv4 identification, muxes payload bytes from the granted source, and enforces an inter-frame gap plus a stall watchdog. It sits between the source blocks and the mac instance in the top level.

Parameters:
N_SRC, 2, number of requesters (2..4)
IFG_CYCLES, 16'd48, idle clocks between end of busy and next start
TIMEOUT_CYCLES, 24'd1_000_000, max clocks in WAIT_BUSY or SEND before abort
IPV4_ID_INIT, 16'h0123, first IPv4 identification value after reset

Ports:
I_clk50m  in  1  RMII reference clock, all logic on rising edge
I_rst  in  1  asynchronous active-low reset
I_req  in  N_SRC  per-source frame request, level, held until grant
I_len  in  N_SRC*16  per-source UDP payload length, slice i = [16*i+15:16*i]
I_data  in  N_SRC*8  per-source payload byte, valid while its O_rd is high
O_gnt  out  N_SRC  one-hot grant, held for the whole frame
O_rd  out  N_SRC  per-source byte-fetch strobe (granted source only)
O_done  out  N_SRC  one-cycle pulse: frame completed normally
O_abort  out  N_SRC  one-cycle pulse: frame aborted by watchdog
O_mac_en  out  1  to mac I_en
O_mac_data  out  8  to mac I_data
O_mac_len  out  16  to mac I_dataLen
O_mac_ipv4sign  out  16  to mac I_ipv4sign
I_mac_busy  in  1  from mac O_busy
I_mac_load  in  1  from mac O_isLoadData
O_frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0

Behaviour:
- Reset (I_rst low, async): state IDLE; O_gnt, O_rd, O_done, O_abort, O_mac_en = 0; O_mac_data = 8'h00; O_mac_len = 0; O_mac_ipv4sign = IPV4_ID_INIT; O_frame_cnt = 0; RR pointer = 0; counters = 0.
- FSM states: IDLE, START, WAIT_BUSY, SEND, GAP.
- IDLE: if any I_req, pick first requesting index at or after RR pointer (wrap mod N_SRC); next cycle O_gnt one-hot, O_mac_len latched from I_len slice, state START. Request changes after grant are ignored.
- START: O_mac_en = 1 for exactly one cycle; go WAIT_BUSY, watchdog cleared.
- WAIT_BUSY: wait for I_mac_busy = 1 -> SEND. Watchdog reaching TIMEOUT_CYCLES -> abort path.
- SEND: O_rd[g] = I_mac_load (combinational); O_mac_data = I_data slice g when granted, else 8'h00 (combinational mux, zero latency). On I_mac_busy falling (registered edge detect): O_done[g] pulse, O_frame_cnt+1, O_mac_ipv4sign+1 (wraps), RR pointer = g+1 mod N_SRC, O_gnt cleared, GAP. Watchdog in SEND counts total cycles; expiry -> abort path.
- Abort path: O_abort[g] pulse, O_gnt cleared, RR pointer advanced, ipv4sign and frame_cnt unchanged, go GAP.
- GAP: count IFG_CYCLES clocks with I_mac_busy low (counter restarts if busy seen high), then IDLE. IFG_CYCLES = 0 -> IDLE next cycle.
- O_mac_len stable from grant until GAP exit.
- I_mac_load high outside SEND: ignored, O_rd stays 0.
- Zero-length request (I_len = 0): still sent (header-only frame).
- Reset mid-frame: immediate return to reset values; no done/abort pulse.

Decomposition:
- Package mac_tx_pkg: state enum sched_state_e, constants IPV4_ID_INIT default, lane-width localparams (DATA_W = 8, LEN_W = 16).
- Sub-module rr_arbiter (request vector + pointer -> one-hot grant, index); remainder is FSM, counters, and mux.

Test Plan:
- Single source: I_req[0]=1, len 222 -> O_mac_en one-cycle pulse, O_mac_len=222, O_mac_ipv4sign=16'h0123 during frame, O_done[0] after busy falls, ipv4sign becomes 16'h0124, O_frame_cnt=1.
- Both sources requesting continuously, 4 frames -> grant order 0,1,0,1; every start separated from previous busy-fall by >=48 clocks.
- Data mux: source 1 granted, I_data[15:8]=8'h5A, I_mac_load pulsed -> O_rd=2'b10, O_mac_data=8'h5A in the same cycle; O_rd[0] never asserted.
- Watchdog: mac model never raises busy, TIMEOUT_CYCLES=100 -> O_abort[g] pulse ~101 cycles after O_mac_en; ipv4sign unchanged; next request served after GAP.
- Wrap: preset path with IPV4_ID_INIT=16'hFFFF, one frame -> ipv4sign=16'h0000.
- Reset mid-SEND -> all outputs at reset values asynchronously; new request after release restarts at source 0 with ipv4sign = IPV4_ID_INIT.

Source files
------------

// File: rtl/mac_tx_pkg.sv
// Shared types and lane widths for the MAC transmit scheduler.
// Pure declarations; no logic.
package mac_tx_pkg;

    localparam int          DATA_W           = 8;
    localparam int          LEN_W            = 16;
    localparam int          WDOG_W           = 24;
    localparam logic [15:0] IPV4_ID_INIT_DEF = 16'h0123;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_SEND      = 3'd3,
        S_GAP       = 3'd4
    } sched_state_e;

endpackage

// File: rtl/mac_tx_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, wrapping modulo N_SRC.
// Purely combinational; no backpressure (caller samples when it is ready).
module rr_arbiter #(
    parameter int N_SRC = 2,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    always_comb begin
        vld_o = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_SRC)) begin
                cand = cand - (IDX_W+1)'(N_SRC);
            end
            if (!vld_o && req_i[cand[IDX_W-1:0]]) begin
                vld_o                  = 1'b1;
                gnt_o[cand[IDX_W-1:0]] = 1'b1;
                idx_o                  = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mac_tx_sched.sv
// Shares one UDP/MAC transmitter between N_SRC sources: arbitrate, start, mux bytes, enforce gap and watchdog.
// Grant 1 clk after request; O_rd/O_mac_data combinational in SEND; sources hold I_req until granted.
module mac_tx_sched
    import mac_tx_pkg::*;
#(
    parameter int          N_SRC          = 2,
    parameter logic [15:0] IFG_CYCLES     = 16'd48,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [15:0] IPV4_ID_INIT   = IPV4_ID_INIT_DEF
) (
    input  logic                    I_clk50m,
    input  logic                    I_rst,
    input  logic [N_SRC-1:0]        I_req,
    input  logic [N_SRC*LEN_W-1:0]  I_len,
    input  logic [N_SRC*DATA_W-1:0] I_data,
    output logic [N_SRC-1:0]        O_gnt,
    output logic [N_SRC-1:0]        O_rd,
    output logic [N_SRC-1:0]        O_done,
    output logic [N_SRC-1:0]        O_abort,
    output logic                    O_mac_en,
    output logic [DATA_W-1:0]       O_mac_data,
    output logic [LEN_W-1:0]        O_mac_len,
    output logic [15:0]             O_mac_ipv4sign,
    input  logic                    I_mac_busy,
    input  logic                    I_mac_load,
    output logic [15:0]             O_frame_cnt
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    sched_state_e       state_q, state_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [15:0]        ipv4_q, ipv4_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [15:0]        gap_q, gap_d;
    logic [N_SRC-1:0]   done_q, done_d;
    logic [N_SRC-1:0]   abort_q, abort_d;
    logic               busy_q;

    logic               arb_vld;
    logic [N_SRC-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [LEN_W-1:0]   sel_len;
    logic [DATA_W-1:0]  sel_dat;
    logic [IDX_W-1:0]   nxt_idx;
    logic               wdog_exp;
    logic               busy_fall;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (I_req),
        .ptr_i (rr_ptr_q),
        .vld_o (arb_vld),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Slice muxes: length follows the arbiter pick, data follows the latched grant.
    always_comb begin
        sel_len = '0;
        sel_dat = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_len = I_len[k*LEN_W +: LEN_W];
            end
            if (gidx_q == IDX_W'(k)) begin
                sel_dat = I_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign nxt_idx   = (gidx_q == IDX_W'(N_SRC-1)) ? '0 : gidx_q + IDX_W'(1);
    assign wdog_exp  = ({1'b0, wdog_q} + (WDOG_W+1)'(1)) >= {1'b0, TIMEOUT_CYCLES};
    assign busy_fall = busy_q && !I_mac_busy;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        len_d       = len_q;
        ipv4_d      = ipv4_q;
        frame_cnt_d = frame_cnt_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        done_d      = '0;
        abort_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    len_d   = sel_len;
                    state_d = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (I_mac_busy) begin
                    wdog_d  = '0;
                    state_d = S_SEND;
                end else if (wdog_exp) begin
                    abort_d  = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = nxt_idx;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_SEND: begin
                // A completed frame wins over a watchdog expiry in the same cycle.
                if (busy_fall) begin
                    done_d      = gnt_q;
                    gnt_d       = '0;
                    rr_ptr_d    = nxt_idx;
                    ipv4_d      = ipv4_q + 16'd1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_d       = '0;
                    state_d     = S_GAP;
                end else if (wdog_exp) begin
                    abort_d  = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = nxt_idx;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_GAP: begin
                if (IFG_CYCLES == 16'd0) begin
                    state_d = S_IDLE;
                end else if (I_mac_busy) begin
                    gap_d = '0;
                end else if (({1'b0, gap_q} + 17'd1) >= {1'b0, IFG_CYCLES}) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk50m or negedge I_rst) begin
        if (!I_rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            len_q       <= '0;
            ipv4_q      <= IPV4_ID_INIT;
            frame_cnt_q <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
            done_q      <= '0;
            abort_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            len_q       <= len_d;
            ipv4_q      <= ipv4_d;
            frame_cnt_q <= frame_cnt_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            busy_q      <= I_mac_busy;
        end
    end

    assign O_gnt          = gnt_q;
    assign O_rd           = (state_q == S_SEND && I_mac_load) ? gnt_q : '0;
    assign O_done         = done_q;
    assign O_abort        = abort_q;
    assign O_mac_en       = (state_q == S_START);
    assign O_mac_data     = (|gnt_q) ? sel_dat : '0;
    assign O_mac_len      = len_q;
    assign O_mac_ipv4sign = ipv4_q;
    assign O_frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_sched.sv
// Randomised bench for mac_tx_sched with a frame-level reference model (grant order, IPv4 id, frame count, gap).
module tb_mac_tx_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] len;
    logic [15:0] dat;
    logic [1:0]  gnt, rd, done, abort;
    logic        mac_en;
    logic [7:0]  mac_data;
    logic [15:0] mac_len, ipv4, fcnt;
    logic        busy, load;

    logic [1:0]  req2;
    logic [31:0] len2;
    logic [15:0] dat2;
    logic [1:0]  gnt2, rd2, done2, abort2;
    logic        mac_en2;
    logic [7:0]  mac_data2;
    logic [15:0] mac_len2, ipv42, fcnt2;
    logic        busy2, load2;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    int          m_ptr;
    logic [15:0] m_ipv4;
    logic [15:0] m_cnt;
    int          last_fall;

    mac_tx_sched #(
        .N_SRC(2), .IFG_CYCLES(16'd48), .TIMEOUT_CYCLES(24'd100), .IPV4_ID_INIT(16'h0123)
    ) dut (
        .I_clk50m(clk), .I_rst(rst_n), .I_req(req), .I_len(len), .I_data(dat),
        .O_gnt(gnt), .O_rd(rd), .O_done(done), .O_abort(abort), .O_mac_en(mac_en),
        .O_mac_data(mac_data), .O_mac_len(mac_len), .O_mac_ipv4sign(ipv4),
        .I_mac_busy(busy), .I_mac_load(load), .O_frame_cnt(fcnt)
    );

    mac_tx_sched #(
        .N_SRC(2), .IFG_CYCLES(16'd48), .TIMEOUT_CYCLES(24'd1_000_000), .IPV4_ID_INIT(16'hFFFF)
    ) dut_wrap (
        .I_clk50m(clk), .I_rst(rst_n), .I_req(req2), .I_len(len2), .I_data(dat2),
        .O_gnt(gnt2), .O_rd(rd2), .O_done(done2), .O_abort(abort2), .O_mac_en(mac_en2),
        .O_mac_data(mac_data2), .O_mac_len(mac_len2), .O_mac_ipv4sign(ipv42),
        .I_mac_busy(busy2), .I_mac_load(load2), .O_frame_cnt(fcnt2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [1:0] r);
        for (int k = 0; k < 2; k++) begin
            if (r[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_ipv4    = 16'h0123;
        m_cnt     = 16'd0;
        last_fall = cyc - 1000;
    endtask

    task automatic do_reset();
        req = '0; busy = 1'b0; load = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    // One complete frame against the model: grant pick, start pulse, byte mux, done, counters.
    task automatic run_frame(input logic [1:0] reqv, input int force_len, input bit fix5a, input bit rereq);
        logic [15:0] lens [2];
        logic [1:0]  exp_gnt;
        int g, t, n, fall_cyc;
        lens[0] = 16'($urandom);
        lens[1] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) lens[$urandom_range(0, 1)] = 16'd0;
        g = model_pick(reqv);
        if (force_len >= 0) lens[g] = 16'(force_len);
        exp_gnt = 2'b01 << g;
        len = {lens[1], lens[0]};
        req = reqv;
        t = 0;
        while (mac_en !== 1'b1 && t < 200) begin step(); t++; end
        vecs++;
        if (mac_en !== 1'b1) begin
            errs++; $display("FAIL start_timeout mac_en=%b want 1", mac_en);
            req = '0; return;
        end
        vecs++;
        if (gnt !== exp_gnt) begin errs++; $display("FAIL grant got=%b want=%b", gnt, exp_gnt); end
        vecs++;
        if (mac_len !== lens[g]) begin errs++; $display("FAIL len_latch got=%0d want=%0d", mac_len, lens[g]); end
        vecs++;
        if (ipv4 !== m_ipv4) begin errs++; $display("FAIL ipv4_during got=%h want=%h", ipv4, m_ipv4); end
        vecs++;
        if (cyc - last_fall < 48) begin errs++; $display("FAIL ifg got=%0d want>=48", cyc - last_fall); end
        req[g] = 1'b0;
        len = {16'($urandom), 16'($urandom)};
        step();
        vecs++;
        if (mac_en !== 1'b0) begin errs++; $display("FAIL en_pulse got=%b want=0", mac_en); end
        load = 1'b1;
        #1;
        vecs++;
        if (rd !== 2'b00) begin errs++; $display("FAIL rd_outside_send got=%b want=00", rd); end
        step();
        load = 1'b0; busy = 1'b1;
        step();
        n = $urandom_range(3, 20);
        for (int i = 0; i < n; i++) begin
            load = 1'($urandom_range(0, 1));
            dat  = 16'($urandom);
            if (fix5a) dat[8*g +: 8] = 8'h5A;
            #1;
            vecs++;
            if (rd !== (load ? exp_gnt : 2'b00)) begin
                errs++; $display("FAIL rd_strobe got=%b want=%b", rd, load ? exp_gnt : 2'b00);
            end
            vecs++;
            if (mac_data !== dat[8*g +: 8]) begin
                errs++; $display("FAIL data_mux got=%h want=%h", mac_data, dat[8*g +: 8]);
            end
            step();
        end
        busy = 1'b0; load = 1'b0;
        fall_cyc = cyc;
        t = 0;
        do begin step(); t++; end while (done === 2'b00 && t < 5);
        vecs++;
        if (done !== exp_gnt) begin errs++; $display("FAIL done got=%b want=%b", done, exp_gnt); end
        m_ipv4 = m_ipv4 + 16'd1;
        m_cnt  = m_cnt + 16'd1;
        m_ptr  = (g + 1) % 2;
        last_fall = fall_cyc;
        vecs++;
        if (gnt !== 2'b00) begin errs++; $display("FAIL gnt_clear got=%b want=00", gnt); end
        vecs++;
        if (ipv4 !== m_ipv4) begin errs++; $display("FAIL ipv4_after got=%h want=%h", ipv4, m_ipv4); end
        vecs++;
        if (fcnt !== m_cnt) begin errs++; $display("FAIL frame_cnt got=%0d want=%0d", fcnt, m_cnt); end
        vecs++;
        if (mac_len !== lens[g]) begin errs++; $display("FAIL len_stable got=%0d want=%0d", mac_len, lens[g]); end
        if (rereq) req[g] = 1'b1;
        step();
        vecs++;
        if (done !== 2'b00) begin errs++; $display("FAIL done_pulse got=%b want=00", done); end
    endtask

    task automatic test_reset();
        req = '0; len = '0; dat = '0; busy = 1'b0; load = 1'b0;
        req2 = '0; len2 = '0; dat2 = '0; busy2 = 1'b0; load2 = 1'b0;
        rst_n = 1'b0;
        step(); step();
        vecs++;
        if ({gnt, rd, done, abort, mac_en} !== 9'd0) begin
            errs++; $display("FAIL reset_ctrl got=%b want=0", {gnt, rd, done, abort, mac_en});
        end
        vecs++;
        if ({mac_data, mac_len, fcnt} !== 40'd0) begin
            errs++; $display("FAIL reset_data got=%h want=0", {mac_data, mac_len, fcnt});
        end
        vecs++;
        if (ipv4 !== 16'h0123) begin errs++; $display("FAIL reset_ipv4 got=%h want=0123", ipv4); end
        vecs++;
        if (ipv42 !== 16'hFFFF) begin errs++; $display("FAIL reset_ipv4_wrap got=%h want=ffff", ipv42); end
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_single();
        run_frame(2'b01, 222, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(2'b11, -1, 1'b0, 1'b1);
        req = '0;
    endtask

    task automatic test_data_mux();
        run_frame(2'b10, -1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) run_frame(2'($urandom_range(1, 3)), -1, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_watchdog();
        int t, c0;
        req = 2'b01;
        t = 0;
        while (mac_en !== 1'b1 && t < 200) begin step(); t++; end
        c0 = cyc;
        req = 2'b00;
        t = 0;
        while (abort === 2'b00 && t < 200) begin step(); t++; end
        vecs++;
        if (abort !== 2'b01) begin errs++; $display("FAIL abort got=%b want=01", abort); end
        vecs++;
        if (cyc - c0 < 100 || cyc - c0 > 102) begin
            errs++; $display("FAIL abort_latency got=%0d want=101", cyc - c0);
        end
        vecs++;
        if ({done, gnt} !== 4'b0000) begin errs++; $display("FAIL abort_side got=%b want=0000", {done, gnt}); end
        vecs++;
        if (ipv4 !== m_ipv4 || fcnt !== m_cnt) begin
            errs++; $display("FAIL abort_counts got=%h/%0d want=%h/%0d", ipv4, fcnt, m_ipv4, m_cnt);
        end
        m_ptr = 1;
        last_fall = cyc;
        run_frame(2'b11, -1, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_wrap();
        int t;
        req2 = 2'b01; len2 = 32'h0000_0010;
        t = 0;
        while (mac_en2 !== 1'b1 && t < 200) begin step(); t++; end
        vecs++;
        if (ipv42 !== 16'hFFFF || mac_en2 !== 1'b1) begin
            errs++; $display("FAIL wrap_start got=%h en=%b want=ffff en=1", ipv42, mac_en2);
        end
        req2 = 2'b00;
        step();
        busy2 = 1'b1;
        step(); step(); step();
        busy2 = 1'b0;
        t = 0;
        do begin step(); t++; end while (done2 === 2'b00 && t < 5);
        vecs++;
        if (ipv42 !== 16'h0000) begin errs++; $display("FAIL wrap_ipv4 got=%h want=0000", ipv42); end
        vecs++;
        if (fcnt2 !== 16'd1) begin errs++; $display("FAIL wrap_cnt got=%0d want=1", fcnt2); end
    endtask

    task automatic test_reset_mid();
        int t;
        req = 2'b01;
        t = 0;
        while (mac_en !== 1'b1 && t < 200) begin step(); t++; end
        req = 2'b00;
        step();
        busy = 1'b1;
        step(); step();
        load = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({gnt, rd, done, abort, mac_en} !== 9'd0) begin
            errs++; $display("FAIL midrst_ctrl got=%b want=0", {gnt, rd, done, abort, mac_en});
        end
        vecs++;
        if ({mac_data, mac_len, fcnt} !== 40'd0 || ipv4 !== 16'h0123) begin
            errs++; $display("FAIL midrst_regs got=%h ipv4=%h want=0 ipv4=0123", {mac_data, mac_len, fcnt}, ipv4);
        end
        busy = 1'b0; load = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_reset();
        step();
        run_frame(2'b11, -1, 1'b0, 1'b0);
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_data_mux();
        test_random();
        test_watchdog();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
